lsu_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one data-memory port between NUM_CONSUMERS per-thread LSUs of a core. It accepts level-held valid requests (read or write) from each LSU and forwards one at a time to memory. It waits for the memory ready, then relays ready (and read data) back to the winning LSU. It sits between the LSU array and the memory controller / external data-memory interface.

---
 rtl/lsu_mem_arbiter_if.sv | 47 ++++
 rtl/lsu_mem_arbiter.sv | 108 ++++++++++
 tb/tb_lsu_mem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_arbiter_if.sv
// Bundle of every LSU-side and memory-side signal of the data-memory
// arbiter.
//   master : arbiter view. Drives mem_* requests and consumer_* readies/data.
//   slave  : environment view (LSU array plus memory controller).
// Consumer vectors are packed. Consumer i owns bit i of each valid/ready
// vector, and [i*W +: W] of each address/data vector.
interface lsu_mem_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
           consumer_write_valid, consumer_write_address, consumer_write_data,
           mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
           mem_read_valid, mem_read_address,
           mem_write_valid, mem_write_address, mem_write_data
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
           consumer_write_valid, consumer_write_address, consumer_write_data,
           mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
           mem_read_valid, mem_read_address,
           mem_write_valid, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter that shares one data-memory port among NUM_CONSUMERS
// LSUs. One transaction is in flight at a time. Every output is registered.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : lsu_mem_arbiter_if.master, carrying the LSU requests and
//                readies plus the memory read and write channels
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic               clk,
  input  logic               reset,
  lsu_mem_arbiter_if.master  bus
);
  localparam int PTR_W = $clog2(NUM_CONSUMERS);

  localparam logic [2:0] IDLE          = 3'd0;
  localparam logic [2:0] READ_WAITING  = 3'd1;
  localparam logic [2:0] WRITE_WAITING = 3'd2;
  localparam logic [2:0] READ_RELAY    = 3'd3;
  localparam logic [2:0] WRITE_RELAY   = 3'd4;

  logic [2:0]       r_state;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_grant;

  logic             w_found;
  logic             w_is_read;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_next;
  int               w_j;

  // Find the first requester at or after r_rr_ptr, wrapping around.
  // A read beats a write from the same consumer.
  always_comb begin
    w_found   = 1'b0;
    w_is_read = 1'b0;
    w_idx     = '0;
    w_j       = 0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      w_j = int'(r_rr_ptr) + k;
      if (w_j >= NUM_CONSUMERS) w_j = w_j - NUM_CONSUMERS;
      if (!w_found && (bus.consumer_read_valid[w_j] || bus.consumer_write_valid[w_j])) begin
        w_found   = 1'b1;
        w_idx     = PTR_W'(w_j);
        w_is_read = bus.consumer_read_valid[w_j];
      end
    end
  end

  assign w_next = (int'(r_grant) == NUM_CONSUMERS-1) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state                  <= IDLE;
      r_rr_ptr                 <= '0;
      r_grant                  <= '0;
      bus.mem_read_valid       <= 1'b0;
      bus.mem_read_address     <= '0;
      bus.mem_write_valid      <= 1'b0;
      bus.mem_write_address    <= '0;
      bus.mem_write_data       <= '0;
      bus.consumer_read_ready  <= '0;
      bus.consumer_read_data   <= '0;
      bus.consumer_write_ready <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_grant <= w_idx;
          if (w_is_read) begin
            bus.mem_read_valid   <= 1'b1;
            bus.mem_read_address <= bus.consumer_read_address[int'(w_idx)*ADDR_BITS +: ADDR_BITS];
            r_state              <= READ_WAITING;
          end else begin
            bus.mem_write_valid   <= 1'b1;
            bus.mem_write_address <= bus.consumer_write_address[int'(w_idx)*ADDR_BITS +: ADDR_BITS];
            bus.mem_write_data    <= bus.consumer_write_data[int'(w_idx)*DATA_BITS +: DATA_BITS];
            r_state               <= WRITE_WAITING;
          end
        end
        READ_WAITING: if (bus.mem_read_ready) begin
          bus.mem_read_valid                                            <= 1'b0;
          bus.consumer_read_data[int'(r_grant)*DATA_BITS +: DATA_BITS] <= bus.mem_read_data;
          bus.consumer_read_ready[r_grant]                              <= 1'b1;
          r_state                                                       <= READ_RELAY;
        end
        WRITE_WAITING: if (bus.mem_write_ready) begin
          bus.mem_write_valid               <= 1'b0;
          bus.consumer_write_ready[r_grant] <= 1'b1;
          r_state                           <= WRITE_RELAY;
        end
        // Hold ready until the LSU lowers valid, then advance the pointer.
        READ_RELAY: if (!bus.consumer_read_valid[r_grant]) begin
          bus.consumer_read_ready[r_grant] <= 1'b0;
          r_rr_ptr                         <= w_next;
          r_state                          <= IDLE;
        end
        WRITE_RELAY: if (!bus.consumer_write_valid[r_grant]) begin
          bus.consumer_write_ready[r_grant] <= 1'b0;
          r_rr_ptr                          <= w_next;
          r_state                           <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
module tb_lsu_mem_arbiter;
  localparam int N = 4;

  logic clk;
  logic reset;
  lsu_mem_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)) bus ();

  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected events: 0 mem read, 1 mem write, 2 consumer read ready,
  // 3 consumer write ready.
  typedef struct { int kind; int c; logic [7:0] a; logic [7:0] d; } ev_t;
  ev_t sb[$];

  int checks = 0;
  int failures = 0;
  int tmo_req = 0;
  int tmo_seen = 0;
  bit done = 0;

  logic [7:0] mem_arr [256];
  int mem_delay = 1;
  int mem_cnt = 0;

  // The LSUs drop valid once they see ready. The memory answers mem_delay
  // cycles after valid appears. All DUT inputs are driven only from here
  // and from the main stimulus thread.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (bus.consumer_read_ready[c])  bus.consumer_read_valid[c]  = 1'b0;
      if (bus.consumer_write_ready[c]) bus.consumer_write_valid[c] = 1'b0;
    end
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;
    if (bus.mem_read_valid || bus.mem_write_valid) begin
      mem_cnt++;
      if (mem_cnt >= mem_delay) begin
        mem_cnt = 0;
        if (bus.mem_read_valid) begin
          bus.mem_read_data  = mem_arr[bus.mem_read_address];
          bus.mem_read_ready = 1'b1;
        end else begin
          mem_arr[bus.mem_write_address] = bus.mem_write_data;
          bus.mem_write_ready = 1'b1;
        end
      end
    end else mem_cnt = 0;
  endtask

  task automatic rd(input int c, input logic [7:0] a, input logic [7:0] d);
    sb.push_back('{0, c, a, 8'h00});
    sb.push_back('{2, c, 8'h00, d});
    bus.consumer_read_address[c*8 +: 8] = a;
    bus.consumer_read_valid[c] = 1'b1;
  endtask

  task automatic wr(input int c, input logic [7:0] a, input logic [7:0] d);
    sb.push_back('{1, c, a, d});
    sb.push_back('{3, c, 8'h00, 8'h00});
    bus.consumer_write_address[c*8 +: 8] = a;
    bus.consumer_write_data[c*8 +: 8]    = d;
    bus.consumer_write_valid[c] = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (n < budget && !(bus.consumer_read_valid == 0 && bus.consumer_write_valid == 0 &&
               !bus.mem_read_valid && !bus.mem_write_valid &&
               bus.consumer_read_ready == 0 && bus.consumer_write_ready == 0));
    if (n >= budget) tmo_req++;
  endtask

  // Main stimulus thread
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i) ^ 8'h3C;
    mem_arr[8'h1A] = 8'h5C;
    reset = 1'b1;
    bus.consumer_read_valid = '0;   bus.consumer_read_address = '0;
    bus.consumer_write_valid = '0;  bus.consumer_write_address = '0;
    bus.consumer_write_data = '0;
    bus.mem_read_ready = 1'b0;  bus.mem_read_data = '0;
    bus.mem_write_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Contention straight after reset: grants go 0,1,2,3
    rd(0, 8'h00, 8'h3C); rd(1, 8'h01, 8'h3D); rd(2, 8'h02, 8'h3E); rd(3, 8'h03, 8'h3F);
    wait_idle(100);
    // Single read with a slow memory
    mem_delay = 3;
    rd(2, 8'h1A, 8'h5C);
    wait_idle(50);
    mem_delay = 1;
    // Single write
    wr(1, 8'h40, 8'h77);
    wait_idle(50);
    // Wrap: serve 3 alone, then 0 and 3 together -> 0 first
    rd(3, 8'h10, 8'h2C);
    wait_idle(50);
    rd(0, 8'h40, 8'h77); rd(3, 8'h11, 8'h2D);
    wait_idle(100);
    // Read and write from consumer 0 together: read first
    rd(0, 8'h05, 8'h39); wr(0, 8'h06, 8'h99);
    wait_idle(100);
    // Leave rr_ptr at 3, then reset during READ_WAITING
    rd(2, 8'h30, 8'h0C);
    wait_idle(50);
    mem_delay = 10;
    sb.push_back('{0, 2, 8'h31, 8'h00});
    bus.consumer_read_address[2*8 +: 8] = 8'h31;
    bus.consumer_read_valid[2] = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    bus.consumer_read_valid[2] = 1'b0;
    tick();
    reset = 1'b0;
    mem_delay = 1;
    // rr_ptr is back at 0, so consumer 1 beats consumer 3
    rd(1, 8'h32, 8'h0E); rd(3, 8'h33, 8'h0F);
    wait_idle(100);
    tick(); tick();
    done = 1'b1;
  end

  // Monitor: compares the DUT outputs against the scoreboard
  logic       p_mrv = 0, p_mwv = 0, rst_prev = 0;
  logic [N-1:0] p_crr = '0, p_cwr = '0;
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        checks++;
        if ({bus.mem_read_valid, bus.mem_read_address, bus.mem_write_valid, bus.mem_write_address,
             bus.mem_write_data, bus.consumer_read_ready, bus.consumer_read_data,
             bus.consumer_write_ready} != 0) begin
          failures++;
          $display("FAIL reset_state: mrv=%b mwv=%b crr=%b cwr=%b crd=%h ma=%h wa=%h wd=%h, required all 0",
                   bus.mem_read_valid, bus.mem_write_valid, bus.consumer_read_ready,
                   bus.consumer_write_ready, bus.consumer_read_data, bus.mem_read_address,
                   bus.mem_write_address, bus.mem_write_data);
        end
      end
      checks++;
      if (!$onehot0({bus.mem_read_valid, bus.mem_write_valid}) ||
          !$onehot0({bus.consumer_read_ready, bus.consumer_write_ready})) begin
        failures++;
        $display("FAIL onehot: mrv=%b mwv=%b crr=%b cwr=%b, required at most one of each group",
                 bus.mem_read_valid, bus.mem_write_valid, bus.consumer_read_ready, bus.consumer_write_ready);
      end
      if (bus.mem_read_valid && !p_mrv) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL mem_read: addr=%h, required no event", bus.mem_read_address); end
        else begin
          e = sb.pop_front();
          if (e.kind != 0 || bus.mem_read_address != e.a) begin
            failures++;
            $display("FAIL mem_read: kind=0 addr=%h, required kind=%0d addr=%h", bus.mem_read_address, e.kind, e.a);
          end
        end
      end
      if (bus.mem_write_valid && !p_mwv) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL mem_write: addr=%h, required no event", bus.mem_write_address); end
        else begin
          e = sb.pop_front();
          if (e.kind != 1 || bus.mem_write_address != e.a || bus.mem_write_data != e.d) begin
            failures++;
            $display("FAIL mem_write: kind=1 addr=%h data=%h, required kind=%0d addr=%h data=%h",
                     bus.mem_write_address, bus.mem_write_data, e.kind, e.a, e.d);
          end
        end
      end
      if ((bus.consumer_read_ready & ~p_crr) != 0) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL rd_ready: crr=%b, required no event", bus.consumer_read_ready); end
        else begin
          e = sb.pop_front();
          if (e.kind != 2 || bus.consumer_read_ready != N'(1 << e.c) ||
              bus.consumer_read_data[e.c*8 +: 8] != e.d) begin
            failures++;
            $display("FAIL rd_ready: crr=%b data=%h, required kind=%0d crr=%b data=%h",
                     bus.consumer_read_ready, bus.consumer_read_data[e.c*8 +: 8], e.kind, N'(1 << e.c), e.d);
          end
        end
      end
      if ((bus.consumer_write_ready & ~p_cwr) != 0) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL wr_ready: cwr=%b, required no event", bus.consumer_write_ready); end
        else begin
          e = sb.pop_front();
          if (e.kind != 3 || bus.consumer_write_ready != N'(1 << e.c)) begin
            failures++;
            $display("FAIL wr_ready: cwr=%b, required kind=%0d cwr=%b", bus.consumer_write_ready, e.kind, N'(1 << e.c));
          end
        end
      end
      p_mrv = bus.mem_read_valid;  p_mwv = bus.mem_write_valid;
      p_crr = bus.consumer_read_ready;  p_cwr = bus.consumer_write_ready;
      rst_prev = reset;
      while (tmo_seen < tmo_req) begin
        tmo_seen++; checks++; failures++;
        $display("FAIL timeout: transaction not idle within budget, required completion");
      end
      if (done) begin
        checks++;
        if (sb.size() != 0) begin
          failures++;
          $display("FAIL sb_drain: %0d events outstanding, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
